// File: rtl/dna_job_scheduler.sv
// dna_job_scheduler: queues alignment job descriptors and runs them one at a time on the DNA
// scoring core. Each job goes through SETUP (config stable), RUN (core start held), DRAIN (core
// returns to idle) and REPORT (result record offered until consumed).
// Optional feature: define DNA_SCHED_TIMEOUT_EN to enable the RUN-cycle timeout; without it
// timeout_i is ignored and status 011 never occurs.
module dna_job_scheduler #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16,
  parameter int unsigned LEN_W = 7,
  parameter int unsigned ID_W  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  // Job descriptor input
  input  logic                         job_valid_i,
  output logic                         job_ready_o,
  input  logic [LEN_W-1:0]             job_len_i,
  input  logic [2:0]                   job_match_i,
  input  logic [2:0]                   job_mismatch_i,
  input  logic [2:0]                   job_gap_i,
  input  logic [ID_W-1:0]              job_id_i,
  // Scoring core control
  output logic                         core_start_o,
  output logic [LEN_W-1:0]             core_len_o,
  output logic [2:0]                   core_match_o,
  output logic [2:0]                   core_mismatch_o,
  output logic [2:0]                   core_gap_o,
  input  logic                         core_done_i,
  input  logic                         core_ref_empty_i,
  input  logic                         core_matrix_full_i,
  // Control
  input  logic                         abort_i,
  input  logic [CNT_W-1:0]             timeout_i,
  // Result record
  output logic                         result_valid_o,
  input  logic                         result_ready_i,
  output logic [ID_W-1:0]              result_id_o,
  output logic [2:0]                   result_status_o,
  output logic [CNT_W-1:0]             result_cycles_o,
  // Status
  output logic                         busy_o,
  output logic [$clog2(DEPTH+1)-1:0]   queue_count_o
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned QCNT_W = $clog2(DEPTH + 1);
  localparam int unsigned DESC_W = LEN_W + 9 + ID_W;

  localparam logic [2:0] StatOk        = 3'b000;
  localparam logic [2:0] StatRefEmpty  = 3'b001;
  localparam logic [2:0] StatMatrixFul = 3'b010;
  localparam logic [2:0] StatTimeout   = 3'b011;
  localparam logic [2:0] StatAborted   = 3'b100;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StRun,
    StDrain,
    StReport
  } state_e;

  state_e state_q, state_d;

  // Job FIFO
  logic [DESC_W-1:0] fifo_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [QCNT_W-1:0] count_q;
  logic [DESC_W-1:0] push_desc;
  logic [DESC_W-1:0] head_desc;
  logic              push;
  logic              pop;

  // Per-job registers
  logic [LEN_W-1:0]  len_q;
  logic [2:0]        match_q, mismatch_q, gap_q;
  logic [ID_W-1:0]   id_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_inc;
  logic [2:0]        status_q;
  logic              drain_q;

  // RUN exit decode
  logic              run_exit;
  logic [2:0]        exit_status;
  logic              timeout_hit;

  // Pushes are refused during reset and while an abort is flushing the queue.
  assign job_ready_o = !rst && (count_q != QCNT_W'(DEPTH)) && !abort_i;
  assign push        = job_valid_i && job_ready_o;
  // An abort in IDLE flushes the head too, so it must not also be popped.
  assign pop         = (state_q == StIdle) && (count_q != '0) && !abort_i;

  assign push_desc = {job_id_i, job_gap_i, job_mismatch_i, job_match_i, job_len_i};
  assign head_desc = fifo_q[rd_ptr_q];

  // Descriptor storage; emptiness is tracked by count_q, so the array needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= push_desc;
    end
  end

  // FIFO pointers and occupancy; abort flushes everything queued.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (abort_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + QCNT_W'(1);
      end else if (pop && !push) begin
        count_q <= count_q - QCNT_W'(1);
      end
    end
  end

  // Saturating RUN cycle number: value of the current RUN cycle (1 in the first one).
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

`ifdef DNA_SCHED_TIMEOUT_EN
  assign timeout_hit = (timeout_i != '0) && (cnt_inc == timeout_i);
`else
  logic unused_timeout;
  assign unused_timeout = ^timeout_i;
  assign timeout_hit    = 1'b0;
`endif

  // Prioritised RUN exit: abort > done > matrix_full > ref_empty > timeout.
  always_comb begin
    run_exit    = 1'b1;
    exit_status = StatOk;
    if (abort_i) begin
      exit_status = StatAborted;
    end else if (core_done_i) begin
      exit_status = StatOk;
    end else if (core_matrix_full_i) begin
      exit_status = StatMatrixFul;
    end else if (core_ref_empty_i) begin
      exit_status = StatRefEmpty;
    end else if (timeout_hit) begin
      exit_status = StatTimeout;
    end else begin
      run_exit = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (pop) begin
          state_d = StSetup;
        end
      end
      StSetup: begin
        state_d = abort_i ? StDrain : StRun;
      end
      StRun: begin
        if (run_exit) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (drain_q) begin
          state_d = StReport;
        end
      end
      StReport: begin
        if (result_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Job config, cycle counter, exit status and drain timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q      <= '0;
      match_q    <= '0;
      mismatch_q <= '0;
      gap_q      <= '0;
      id_q       <= '0;
      cnt_q      <= '0;
      status_q   <= StatOk;
      drain_q    <= 1'b0;
    end else begin
      if (pop) begin
        len_q      <= head_desc[LEN_W-1:0];
        match_q    <= head_desc[LEN_W +: 3];
        mismatch_q <= head_desc[LEN_W+3 +: 3];
        gap_q      <= head_desc[LEN_W+6 +: 3];
        id_q       <= head_desc[LEN_W+9 +: ID_W];
      end
      // Two DRAIN cycles: drain_q is 0 in the first and 1 in the second.
      drain_q <= (state_q == StDrain) && !drain_q;
      if (state_q == StSetup) begin
        cnt_q <= '0;
        if (abort_i) begin
          status_q <= StatAborted;
        end
      end else if (state_q == StRun) begin
        cnt_q <= cnt_inc;
        if (run_exit) begin
          status_q <= exit_status;
        end
      end
    end
  end

  // FSM outputs and result record.
  always_comb begin
    core_start_o    = (state_q == StRun);
    result_valid_o  = (state_q == StReport);
    busy_o          = (state_q != StIdle);
    core_len_o      = len_q;
    core_match_o    = match_q;
    core_mismatch_o = mismatch_q;
    core_gap_o      = gap_q;
    result_id_o     = id_q;
    result_status_o = status_q;
    result_cycles_o = cnt_q;
    queue_count_o   = count_q;
  end

endmodule

// File: tb/tb_dna_job_scheduler.sv
// Directed self-checking bench for dna_job_scheduler (DEPTH=4, CNT_W=16, LEN_W=7, ID_W=4).
module tb_dna_job_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        job_valid_i;
  logic        job_ready_o;
  logic [6:0]  job_len_i;
  logic [2:0]  job_match_i, job_mismatch_i, job_gap_i;
  logic [3:0]  job_id_i;
  logic        core_start_o;
  logic [6:0]  core_len_o;
  logic [2:0]  core_match_o, core_mismatch_o, core_gap_o;
  logic        core_done_i, core_ref_empty_i, core_matrix_full_i;
  logic        abort_i;
  logic [15:0] timeout_i;
  logic        result_valid_o;
  logic        result_ready_i;
  logic [3:0]  result_id_o;
  logic [2:0]  result_status_o;
  logic [15:0] result_cycles_o;
  logic        busy_o;
  logic [2:0]  queue_count_o;

  int total = 0;
  int bad   = 0;
  int max_q = 0;

  dna_job_scheduler #(
    .DEPTH(4), .CNT_W(16), .LEN_W(7), .ID_W(4)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .job_valid_i        (job_valid_i),
    .job_ready_o        (job_ready_o),
    .job_len_i          (job_len_i),
    .job_match_i        (job_match_i),
    .job_mismatch_i     (job_mismatch_i),
    .job_gap_i          (job_gap_i),
    .job_id_i           (job_id_i),
    .core_start_o       (core_start_o),
    .core_len_o         (core_len_o),
    .core_match_o       (core_match_o),
    .core_mismatch_o    (core_mismatch_o),
    .core_gap_o         (core_gap_o),
    .core_done_i        (core_done_i),
    .core_ref_empty_i   (core_ref_empty_i),
    .core_matrix_full_i (core_matrix_full_i),
    .abort_i            (abort_i),
    .timeout_i          (timeout_i),
    .result_valid_o     (result_valid_o),
    .result_ready_i     (result_ready_i),
    .result_id_o        (result_id_o),
    .result_status_o    (result_status_o),
    .result_cycles_o    (result_cycles_o),
    .busy_o             (busy_o),
    .queue_count_o      (queue_count_o)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are observed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (int'(queue_count_o) > max_q) max_q = int'(queue_count_o);
  endtask

  // Offer one descriptor for exactly one edge.
  task automatic push_job(input logic [6:0] len, input logic [2:0] m, input logic [2:0] mm,
                          input logic [2:0] g, input logic [3:0] id);
    job_len_i      = len;
    job_match_i    = m;
    job_mismatch_i = mm;
    job_gap_i      = g;
    job_id_i       = id;
    job_valid_i    = 1'b1;
    tick();
    job_valid_i    = 1'b0;
  endtask

  task automatic consume();
    result_ready_i = 1'b1;
    tick();
    result_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if ({core_start_o, busy_o, result_valid_o, job_ready_o, queue_count_o} !== 7'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %b want 0000000",
               {core_start_o, busy_o, result_valid_o, job_ready_o, queue_count_o});
    end
    rst = 1'b0;
    #1;
    total++;
    if (job_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: got %b want 1", job_ready_o);
    end
  endtask

  task automatic test_single();
    int hi;
    push_job(7'd20, 3'd2, 3'd1, 3'd1, 4'd3);
    total++;
    if (queue_count_o !== 3'd1) begin
      bad++;
      $display("FAIL single_queue: got %0d want 1", queue_count_o);
    end
    tick();  // SETUP
    total++;
    if ({busy_o, core_start_o, core_len_o, core_match_o, core_mismatch_o, core_gap_o}
        !== {1'b1, 1'b0, 7'd20, 3'd2, 3'd1, 3'd1}) begin
      bad++;
      $display("FAIL single_setup: got %h want %h",
               {busy_o, core_start_o, core_len_o, core_match_o, core_mismatch_o, core_gap_o},
               {1'b1, 1'b0, 7'd20, 3'd2, 3'd1, 3'd1});
    end
    tick();  // RUN cycle 1
    hi = 0;
    for (int k = 1; k <= 10; k++) begin
      if (core_start_o) hi++;
      if (k == 10) core_done_i = 1'b1;
      tick();
    end
    core_done_i = 1'b0;
    total++;
    if (hi !== 10 || core_start_o !== 1'b0) begin
      bad++;
      $display("FAIL single_start_len: got %0d/%b want 10/0", hi, core_start_o);
    end
    tick();
    total++;
    if (result_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL single_valid_early: got %b want 0", result_valid_o);
    end
    tick();  // 3 edges after done
    total++;
    if ({result_valid_o, result_id_o, result_status_o, result_cycles_o}
        !== {1'b1, 4'd3, 3'd0, 16'd10}) begin
      bad++;
      $display("FAIL single_result: got %h want %h",
               {result_valid_o, result_id_o, result_status_o, result_cycles_o},
               {1'b1, 4'd3, 3'd0, 16'd10});
    end
    consume();
    total++;
    if ({result_valid_o, busy_o} !== 2'b00) begin
      bad++;
      $display("FAIL single_idle: got %b want 00", {result_valid_o, busy_o});
    end
  endtask

  task automatic test_back_to_back();
    int acc;
    logic [22:0] got, want;
    max_q = 0;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      job_len_i      = 7'(10 + i);
      job_match_i    = 3'(i);
      job_mismatch_i = 3'd1;
      job_gap_i      = 3'd2;
      job_id_i       = 4'(5 + i);
      job_valid_i    = 1'b1;
      if (job_ready_o) acc++;
      tick();
    end
    job_valid_i = 1'b0;
    total++;
    if (acc !== 5) begin
      bad++;
      $display("FAIL b2b_accepted: got %0d want 5", acc);
    end
    total++;
    if ({queue_count_o, job_ready_o, core_start_o} !== {3'd4, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL b2b_full: got %b want 10001", {queue_count_o, job_ready_o, core_start_o});
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        tick();  // SETUP
        tick();  // RUN cycle 1
        total++;
        if ({core_start_o, core_len_o, core_match_o} !== {1'b1, 7'(10 + i), 3'(i)}) begin
          bad++;
          $display("FAIL b2b_config%0d: got %h want %h", i,
                   {core_start_o, core_len_o, core_match_o}, {1'b1, 7'(10 + i), 3'(i)});
        end
        for (int k = 0; k < i; k++) tick();
      end
      core_done_i = 1'b1;
      tick();
      core_done_i = 1'b0;
      tick();
      tick();
      // Job 0 has been running since 2 edges after its push: it finishes in RUN cycle 3.
      want = {4'(5 + i), 3'd0, (i == 0) ? 16'd3 : 16'(i + 1)};
      got  = {result_id_o, result_status_o, result_cycles_o};
      total++;
      if (result_valid_o !== 1'b1 || got !== want) begin
        bad++;
        $display("FAIL b2b_result%0d: got %b/%h want 1/%h", i, result_valid_o, got, want);
      end
      consume();
    end
    total++;
    if (max_q !== 4) begin
      bad++;
      $display("FAIL b2b_max_queue: got %0d want 4", max_q);
    end
  endtask

  task automatic test_timeout();
    timeout_i = 16'd8;
    push_job(7'd30, 3'd3, 3'd2, 3'd1, 4'd7);
    tick();  // SETUP
    tick();  // RUN cycle 1
    for (int k = 1; k < 8; k++) tick();  // RUN cycle 8
`ifdef DNA_SCHED_TIMEOUT_EN
    tick();
    total++;
    if (core_start_o !== 1'b0) begin
      bad++;
      $display("FAIL timeout_stop: got %b want 0", core_start_o);
    end
    tick();
    tick();
    total++;
    if ({result_valid_o, result_status_o, result_cycles_o} !== {1'b1, 3'd3, 16'd8}) begin
      bad++;
      $display("FAIL timeout_result: got %h want %h",
               {result_valid_o, result_status_o, result_cycles_o}, {1'b1, 3'd3, 16'd8});
    end
`else
    tick();
    total++;
    if (core_start_o !== 1'b1) begin
      bad++;
      $display("FAIL timeout_ignored: got %b want 1", core_start_o);
    end
    tick();
    tick();
    tick();  // RUN cycle 12
    core_done_i = 1'b1;
    tick();
    core_done_i = 1'b0;
    tick();
    tick();
    total++;
    if ({result_valid_o, result_status_o, result_cycles_o} !== {1'b1, 3'd0, 16'd12}) begin
      bad++;
      $display("FAIL timeout_result: got %h want %h",
               {result_valid_o, result_status_o, result_cycles_o}, {1'b1, 3'd0, 16'd12});
    end
`endif
    consume();
    timeout_i = 16'd0;
  endtask

  task automatic test_priority();
    push_job(7'd15, 3'd1, 3'd1, 3'd1, 4'd9);
    tick();  // SETUP: flags here are ignored
    core_done_i      = 1'b1;
    core_ref_empty_i = 1'b1;
    tick();  // RUN cycle 1
    core_done_i      = 1'b0;
    core_ref_empty_i = 1'b0;
    total++;
    if (core_start_o !== 1'b1) begin
      bad++;
      $display("FAIL prio_setup_flags: got %b want 1", core_start_o);
    end
    for (int k = 1; k < 5; k++) tick();  // RUN cycle 5
    core_matrix_full_i = 1'b1;
    core_ref_empty_i   = 1'b1;
    tick();
    core_matrix_full_i = 1'b0;
    core_ref_empty_i   = 1'b0;
    tick();
    tick();
    total++;
    if ({result_valid_o, result_id_o, result_status_o, result_cycles_o}
        !== {1'b1, 4'd9, 3'd2, 16'd5}) begin
      bad++;
      $display("FAIL prio_mfull: got %h want %h",
               {result_valid_o, result_id_o, result_status_o, result_cycles_o},
               {1'b1, 4'd9, 3'd2, 16'd5});
    end
    consume();
    push_job(7'd16, 3'd1, 3'd1, 3'd1, 4'd10);
    tick();  // SETUP
    tick();  // RUN cycle 1
    tick();  // RUN cycle 2
    core_done_i = 1'b1;
    abort_i     = 1'b1;
    tick();
    core_done_i = 1'b0;
    abort_i     = 1'b0;
    tick();
    tick();
    total++;
    if ({result_valid_o, result_id_o, result_status_o, result_cycles_o}
        !== {1'b1, 4'd10, 3'd4, 16'd2}) begin
      bad++;
      $display("FAIL prio_abort_done: got %h want %h",
               {result_valid_o, result_id_o, result_status_o, result_cycles_o},
               {1'b1, 4'd10, 3'd4, 16'd2});
    end
    consume();
  endtask

  task automatic test_abort();
    int viol;
    push_job(7'd11, 3'd1, 3'd1, 3'd1, 4'd1);
    push_job(7'd12, 3'd1, 3'd1, 3'd1, 4'd2);
    push_job(7'd13, 3'd1, 3'd1, 3'd1, 4'd3);
    total++;
    if ({queue_count_o, core_start_o} !== {3'd2, 1'b1}) begin
      bad++;
      $display("FAIL abort_setup: got %b want 0101", {queue_count_o, core_start_o});
    end
    tick();  // RUN cycle 2
    abort_i = 1'b1;
    #1;
    total++;
    if (job_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL abort_ready: got %b want 0", job_ready_o);
    end
    tick();
    abort_i = 1'b0;
    total++;
    if ({queue_count_o, core_start_o, busy_o} !== {3'd0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL abort_flush: got %b want 00001", {queue_count_o, core_start_o, busy_o});
    end
    tick();
    tick();
    total++;
    if ({result_valid_o, result_id_o, result_status_o, result_cycles_o}
        !== {1'b1, 4'd1, 3'd4, 16'd2}) begin
      bad++;
      $display("FAIL abort_result: got %h want %h",
               {result_valid_o, result_id_o, result_status_o, result_cycles_o},
               {1'b1, 4'd1, 3'd4, 16'd2});
    end
    consume();
    viol = 0;
    for (int k = 0; k < 12; k++) begin
      if (core_start_o || result_valid_o || busy_o) viol++;
      tick();
    end
    total++;
    if (viol !== 0 || queue_count_o !== 3'd0) begin
      bad++;
      $display("FAIL abort_quiet: got %0d/%0d want 0/0", viol, queue_count_o);
    end
  endtask

  task automatic test_reset_mid();
    push_job(7'd21, 3'd4, 3'd3, 3'd2, 4'd4);
    push_job(7'd22, 3'd4, 3'd3, 3'd2, 4'd5);
    tick();  // RUN cycle 1
    tick();
    tick();  // RUN cycle 3
    rst = 1'b1;
    tick();
    total++;
    if ({core_start_o, busy_o, result_valid_o, job_ready_o, queue_count_o, core_len_o,
         core_match_o, core_mismatch_o, core_gap_o, result_id_o, result_status_o,
         result_cycles_o} !== '0) begin
      bad++;
      $display("FAIL rst_mid_outputs: got %h want 0",
               {core_start_o, busy_o, result_valid_o, job_ready_o, queue_count_o, core_len_o,
                core_match_o, core_mismatch_o, core_gap_o, result_id_o, result_status_o,
                result_cycles_o});
    end
    rst = 1'b0;
    #1;
    total++;
    if (job_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_ready: got %b want 1", job_ready_o);
    end
    push_job(7'd9, 3'd2, 3'd2, 3'd2, 4'd2);
    tick();  // SETUP
    tick();  // RUN cycle 1
    total++;
    if ({core_start_o, core_len_o} !== {1'b1, 7'd9}) begin
      bad++;
      $display("FAIL rst_mid_fresh: got %h want %h", {core_start_o, core_len_o}, {1'b1, 7'd9});
    end
    tick();
    tick();
    tick();  // RUN cycle 4
    core_done_i = 1'b1;
    tick();
    core_done_i = 1'b0;
    tick();
    tick();
    total++;
    if ({result_valid_o, result_id_o, result_status_o, result_cycles_o}
        !== {1'b1, 4'd2, 3'd0, 16'd4}) begin
      bad++;
      $display("FAIL rst_mid_result: got %h want %h",
               {result_valid_o, result_id_o, result_status_o, result_cycles_o},
               {1'b1, 4'd2, 3'd0, 16'd4});
    end
    consume();
    total++;
    if ({busy_o, queue_count_o} !== 4'd0) begin
      bad++;
      $display("FAIL rst_mid_empty: got %b want 0000", {busy_o, queue_count_o});
    end
  endtask

  initial begin
    rst                = 1'b1;
    job_valid_i        = 1'b0;
    job_len_i          = '0;
    job_match_i        = '0;
    job_mismatch_i     = '0;
    job_gap_i          = '0;
    job_id_i           = '0;
    core_done_i        = 1'b0;
    core_ref_empty_i   = 1'b0;
    core_matrix_full_i = 1'b0;
    abort_i            = 1'b0;
    timeout_i          = '0;
    result_ready_i     = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_timeout();
    test_priority();
    test_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
